// File: rtl/lcd_frame_refresher.sv
// lcd_frame_refresher: accepts a full LINES x CHARS frame and rewrites only the
// lines that differ from what was last written, one HD44780 byte at a time.
//
// Handshake: a frame transfers on a rising clk edge where frame_valid and
// frame_ready are both high; frame_ready is high only in IDLE with init_done=1,
// and the producer must hold frame_valid and frame_data until that edge.
module lcd_frame_refresher #(
    parameter int         LINES           = 4,
    parameter int         CHARS           = 20,
    parameter logic [6:0] LINE_STARTS [4] = '{7'h00, 7'h40, 7'h14, 7'h54},
    parameter int         SETUP_CYC       = 2,
    parameter int         E_HIGH_CYC      = 25,
    parameter int         WAIT_CYC        = 2500
) (
    input  logic                     clk,
    input  logic                     lcd_reset,
    input  logic                     init_done,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic [LINES*CHARS*8-1:0] frame_data,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic                     lcd_e,
    output logic [7:0]               lcd_data,
    output logic                     busy,
    output logic                     refresh_done,
    output logic [2:0]               dbg_state
);

    localparam int FW   = LINES * CHARS * 8;
    localparam int LNW  = CHARS * 8;
    localparam int LW   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BW   = $clog2(CHARS + 1);
    localparam int MAXC = (SETUP_CYC > E_HIGH_CYC)
                        ? ((SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC)
                        : ((E_HIGH_CYC > WAIT_CYC) ? E_HIGH_CYC : WAIT_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_SCAN  = 3'd2,
        S_SETUP = 3'd3,
        S_EHIGH = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [FW-1:0]   pending;
    logic [FW-1:0]   shadow;
    logic            shadow_valid;
    logic [LINES-1:0] dirty;
    logic [LINES-1:0] dirty_calc;
    logic            any_dirty;
    logic [LW-1:0]   sel_line;
    logic [LW-1:0]   cur_line;
    logic [BW-1:0]   byte_idx;
    logic [CW-1:0]   cnt;
    logic            phase_end;
    logic            last_byte;
    logic            abort_q;
    logic            abort;
    logic            accept;
    logic            rs_q;
    logic [7:0]      data_q;
    logic [7:0]      next_char;
    logic [1:0]      start_idx;

    // Abort is sticky once init_done drops during a refresh.
    assign abort     = abort_q | ~init_done;
    assign accept    = frame_valid & frame_ready;
    assign last_byte = (byte_idx == BW'(CHARS));
    assign start_idx = 2'(sel_line);

    // A line is dirty when any character differs from what was last written,
    // or unconditionally when the shadow contents are not trusted.
    always_comb begin
        dirty_calc = '0;
        for (int l = 0; l < LINES; l++) begin
            dirty_calc[l] = !shadow_valid
                          || (pending[l*LNW +: LNW] != shadow[l*LNW +: LNW]);
        end
    end

    // Lowest-index dirty line wins.
    always_comb begin
        any_dirty = |dirty;
        sel_line  = '0;
        for (int l = LINES - 1; l >= 0; l--) begin
            if (dirty[l]) sel_line = LW'(l);
        end
    end

    // Character for the byte after the current one; byte_idx 0 is the command.
    always_comb begin
        next_char = '0;
        if (!last_byte) begin
            next_char = pending[(int'(cur_line) * CHARS + int'(byte_idx)) * 8 +: 8];
        end
    end

    // End of the current bus phase.
    always_comb begin
        phase_end = 1'b0;
        case (state)
            S_SETUP: phase_end = (cnt == CW'(SETUP_CYC - 1));
            S_EHIGH: phase_end = (cnt == CW'(E_HIGH_CYC - 1));
            S_WAIT:  phase_end = (cnt == CW'(WAIT_CYC - 1));
            default: phase_end = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!lcd_reset) state <= S_IDLE;
        else            state <= next_state;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        next_state   = state;
        frame_ready  = 1'b0;
        busy         = (state != S_IDLE);
        lcd_e        = 1'b0;
        refresh_done = 1'b0;
        case (state)
            S_IDLE: begin
                frame_ready = init_done & lcd_reset;
                if (accept) next_state = S_CMP;
            end
            S_CMP: begin
                next_state = abort ? S_IDLE : S_SCAN;
            end
            S_SCAN: begin
                if (abort)          next_state = S_IDLE;
                else if (any_dirty) next_state = S_SETUP;
                else                next_state = S_DONE;
            end
            S_SETUP: begin
                if (phase_end) next_state = S_EHIGH;
            end
            S_EHIGH: begin
                lcd_e = 1'b1;
                if (phase_end) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (phase_end) begin
                    if (abort)          next_state = S_IDLE;
                    else if (last_byte) next_state = S_SCAN;
                    else                next_state = S_SETUP;
                end
            end
            S_DONE: begin
                refresh_done = 1'b1;
                next_state   = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = data_q;
    assign dbg_state = state;

    // Phase counter, dirty bookkeeping and the byte presented on the bus.
    always_ff @(posedge clk) begin
        if (!lcd_reset) begin
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            shadow_valid <= 1'b0;
            abort_q      <= 1'b0;
            cnt          <= '0;
            dirty        <= '0;
            cur_line     <= '0;
            byte_idx     <= '0;
        end else begin
            cnt     <= (next_state != state) ? '0 : cnt + CW'(1);
            abort_q <= (state != S_IDLE) && abort;
            case (state)
                S_CMP: dirty <= dirty_calc;
                S_SCAN: begin
                    if (any_dirty && !abort) begin
                        cur_line <= sel_line;
                        byte_idx <= '0;
                        rs_q     <= 1'b0;
                        data_q   <= {1'b1, LINE_STARTS[start_idx]};
                    end
                end
                S_WAIT: begin
                    if (phase_end) begin
                        if (last_byte) begin
                            dirty[cur_line] <= 1'b0;
                        end else if (!abort) begin
                            byte_idx <= byte_idx + BW'(1);
                            rs_q     <= 1'b1;
                            data_q   <= next_char;
                        end
                    end
                end
                S_DONE: shadow_valid <= 1'b1;
                default: ;
            endcase
            // Leaving a refresh early means the display no longer matches shadow.
            if ((state != S_IDLE) && (state != S_DONE) && (next_state == S_IDLE)) begin
                shadow_valid <= 1'b0;
            end
        end
    end

    // Frame buffers: pending holds the accepted frame, shadow what is on screen.
    always_ff @(posedge clk) begin
        if (accept) pending <= frame_data;
        if ((state == S_WAIT) && phase_end && last_byte) begin
            shadow[int'(cur_line) * LNW +: LNW] <= pending[int'(cur_line) * LNW +: LNW];
        end
    end

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// Testbench for lcd_frame_refresher with a small two-line, four-column display.
module tb_lcd_frame_refresher;

    localparam int LINES = 2;
    localparam int CHARS = 4;
    localparam int SU    = 1;
    localparam int EH    = 2;
    localparam int WT    = 3;
    localparam int B     = SU + EH + WT;
    localparam int P     = 1 + (CHARS + 1) * B;
    localparam int FW    = LINES * CHARS * 8;
    localparam int LNW   = CHARS * 8;
    localparam logic [6:0] STARTS [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          lcd_reset;
    logic          init_done;
    logic          frame_valid;
    logic          frame_ready;
    logic [FW-1:0] frame_data;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_e;
    logic [7:0]    lcd_data;
    logic          busy;
    logic          refresh_done;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_frame_refresher #(
        .LINES(LINES), .CHARS(CHARS),
        .SETUP_CYC(SU), .E_HIGH_CYC(EH), .WAIT_CYC(WT)
    ) dut (
        .clk(clk), .lcd_reset(lcd_reset), .init_done(init_done),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy),
        .refresh_done(refresh_done), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: one entry per E rise, E width and bus stability while E high.
    logic       prev_e = 1'b0;
    int         e_len  = 0;
    logic [8:0] hold   = '0;
    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            got_q.push_back({lcd_rs, lcd_data});
            hold  = {lcd_rs, lcd_data};
            e_len = 1;
            check("rw_low", lcd_rw, 0);
        end else if (lcd_e) begin
            e_len++;
            check("bus_stable_e", {lcd_rs, lcd_data}, hold);
        end else if (prev_e && lcd_reset) begin
            check("e_width", e_len, EH);
        end
        prev_e = lcd_e;
    end

    // ---------------- reference model ----------------
    logic [FW-1:0] m_shadow = '0;
    bit            m_valid  = 1'b0;

    // Expected bus bytes for a full refresh; returns number of dirty lines.
    task automatic model_frame(input logic [FW-1:0] f, output int k);
        logic [LNW-1:0] nl;
        k = 0;
        exp_q.delete();
        for (int l = 0; l < LINES; l++) begin
            nl = f[l*LNW +: LNW];
            if (!m_valid || nl != m_shadow[l*LNW +: LNW]) begin
                k++;
                exp_q.push_back({1'b0, 1'b1, STARTS[l]});
                for (int c = 0; c < CHARS; c++) exp_q.push_back({1'b1, f[(l*CHARS + c)*8 +: 8]});
            end
        end
        m_shadow = f;
        m_valid  = 1'b1;
    endtask

    function automatic logic [FW-1:0] mk(input string a, input string b);
        logic [FW-1:0] r;
        r = '0;
        for (int c = 0; c < CHARS; c++) begin
            r[c*8 +: 8]           = a[c];
            r[(CHARS + c)*8 +: 8] = b[c];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a frame; n is the acceptance edge number, or -1 on timeout.
    task automatic offer(input logic [FW-1:0] f, output int n);
        got_q.delete();
        frame_data  = f;
        frame_valid = 1'b1;
        n = -1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (frame_ready) begin
                n = cyc + 1;
                break;
            end
            tick();
        end
        check("accept", n >= 0, 1);
        if (n >= 0) tick();
        frame_valid = 1'b0;
    endtask

    // Wait for refresh_done and compare timing and bus bytes to the model.
    task automatic finish_frame(input int n, input int k, input string tag);
        int done_c;
        int bcount;
        done_c = -1;
        bcount = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy) bcount++;
            if (refresh_done) begin
                done_c = cyc + 1;
                break;
            end
            tick();
        end
        check({tag, "_done_cycle"}, done_c - n, 3 + k * P);
        check({tag, "_busy_cycles"}, bcount, 3 + k * P);
        tick();
        check({tag, "_done_pulse"}, refresh_done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_ready_again"}, frame_ready, 1);
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            n;
        int            k;
        int            nb;
        int            tail;
        bit            hit;
        bit            saw_done;
        logic [FW-1:0] f1;
        logic [FW-1:0] f2;
        logic [FW-1:0] f3;
        logic [FW-1:0] f4;
        logic [FW-1:0] fr;

        lcd_reset   = 1'b0;
        init_done   = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_data", lcd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", refresh_done, 0);
        init_done = 1'b1;
        #1;
        check("rst_ready", frame_ready, 0);

        // Frame held while init_done is low is not accepted.
        lcd_reset = 1'b1;
        init_done = 1'b0;
        f1 = mk("ABCD", "WXYZ");
        frame_data  = f1;
        frame_valid = 1'b1;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gate_ready", frame_ready, 0);
            check("gate_busy", busy, 0);
        end
        model_frame(f1, k);
        init_done = 1'b1;
        #1;
        check("gate_ready_up", frame_ready, 1);
        n = cyc + 1;
        tick();
        frame_valid = 1'b0;
        check("gate_accept", busy, 1);
        finish_frame(n, k, "first");
        check("first_cmd0", got_q.size() > 0 ? got_q[0] : 9'h1FF, 9'h080);
        check("first_cmd1", got_q.size() > 5 ? got_q[5] : 9'h1FF, 9'h0C0);

        // Identical frame: nothing written.
        model_frame(f1, k);
        offer(f1, n);
        finish_frame(n, k, "repeat");

        // Only line 1 changes.
        f2 = mk("ABCD", "WXYQ");
        model_frame(f2, k);
        offer(f2, n);
        finish_frame(n, k, "line1");
        check("line1_cmd", got_q.size() > 0 ? got_q[0] : 9'h1FF, 9'h0C0);

        // Reset while E is high mid-line.
        f3 = mk("HELO", "WXYQ");
        model_frame(f3, k);
        offer(f3, n);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (lcd_e && got_q.size() >= 3) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("rstmid_reached", hit, 1);
        lcd_reset = 1'b0;
        tick();
        check("rstmid_e", lcd_e, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", frame_ready, 0);
        check("rstmid_done", refresh_done, 0);
        tick();
        lcd_reset = 1'b1;
        m_valid   = 1'b0;
        model_frame(f3, k);
        offer(f3, n);
        finish_frame(n, k, "post_reset");

        // init_done drops during a data byte.
        f4 = mk("QRST", "MNOP");
        model_frame(f4, k);
        offer(f4, n);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (lcd_e && got_q.size() == 3) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reached", hit, 1);
        nb        = got_q.size();
        init_done = 1'b0;
        tail      = 0;
        saw_done  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (refresh_done) saw_done = 1'b1;
            if (!busy) break;
            tail++;
        end
        check("abort_tail", tail, EH - 1 + WT);
        check("abort_no_done", saw_done, 0);
        check("abort_ready", frame_ready, 0);
        check("abort_bytes", got_q.size(), nb);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("abort_byte", got_q[i], exp_q[i]);
        tick();
        init_done = 1'b1;
        m_valid   = 1'b0;
        model_frame(f4, k);
        offer(f4, n);
        finish_frame(n, k, "post_abort");

        // Random frames, each line independently kept or rewritten.
        fr = f4;
        for (int it = 0; it < 8; it++) begin
            for (int l = 0; l < LINES; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int c = 0; c < CHARS; c++) fr[(l*CHARS + c)*8 +: 8] = 8'(65 + $urandom_range(0, 25));
                end
            end
            model_frame(fr, k);
            offer(fr, n);
            finish_frame(n, k, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Run-time bound.
    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_frame_refresher.md
# lcd_frame_refresher

Parametrised LCD character-write engine: accepts a whole LINES×CHARS frame through a valid/ready handshake and writes only the lines that changed since the last frame to an HD44780-style 8-bit bus. Sits after the LCD initializer; the top level muxes the LCD bus to this block once `init_done` is high. It replaces full-screen rewrites with dirty-line tracking and configurable bus timing.

## Interface
- `LINES`, 4, number of display lines (1–4)
- `CHARS`, 20, characters per line (1–40)
- `LINE_STARTS`, {7'h00,7'h40,7'h14,7'h54}, DDRAM start address per line, index 0 = line 0
- `SETUP_CYC`, 2, clocks RS/DATA are stable before E rises (≥1)
- `E_HIGH_CYC`, 25, clocks E is held high (≥1)
- `WAIT_CYC`, 2500, clocks E is low after each byte before the next byte (≥1)

- `clk` in 1 — 50 MHz system clock
- `lcd_reset` in 1 — reset, synchronous, active-low
- `init_done` in 1 — initializer finished; gates frame acceptance
- `frame_valid` in 1 — frame_data is valid
- `frame_ready` out 1 — block can accept a frame
- `frame_data` in LINES*CHARS*8 — char [l][c] at bits (l*CHARS+c)*8 +: 8
- `lcd_rs` out 1 — 0 = command, 1 = data
- `lcd_rw` out 1 — always 0 (write only)
- `lcd_e` out 1 — enable strobe
- `lcd_data` out 8 — bus byte
- `busy` out 1 — refresh in progress
- `refresh_done` out 1 — one-cycle pulse at end of each accepted frame

## Operation
- States: IDLE, CMP, SCAN, SETUP, EHIGH, WAIT, DONE.
- Reset (`lcd_reset`=0 at an edge): state IDLE; `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00, `frame_ready`=0, `busy`=0, `refresh_done`=0; shadow-valid flag cleared. Takes effect at the same edge even mid-byte; E drops immediately.
- `frame_ready` = (state==IDLE) && `init_done`. Frame is accepted on an edge with valid && ready; `frame_data` is latched into a pending buffer at that edge.
- CMP (1 cycle): dirty[l] = 1 if any char in line l differs from the shadow buffer (last written contents), or if shadow-valid is 0.
- SCAN (1 cycle): choose the lowest-index dirty line. Load byte 0xSet DDRAM command = {1'b1, LINE_STARTS[l]} with RS=0, then go to SETUP. If no line is dirty, go to DONE.
- Per line: 1 command byte, then CHARS data bytes (RS=1) in column order 0..CHARS-1, auto-incrementing on the LCD side.
- Per byte: SETUP for SETUP_CYC cycles (E=0), EHIGH for E_HIGH_CYC cycles (E=1), WAIT for WAIT_CYC cycles (E=0). RS/DATA are held constant from the first SETUP cycle through the last WAIT cycle.
- After the last data byte of line l: copy the pending line l into the shadow, clear dirty[l], and return to SCAN.
- DONE (1 cycle): `refresh_done`=1, set shadow-valid, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `init_done` falling while busy: the block finishes the current byte's WAIT, clears shadow-valid, and returns to IDLE without pulsing `refresh_done`. A frame offered while `init_done`=0 is not accepted.
- `frame_valid` while busy is ignored, with no queuing; the producer holds it until ready.

## Timing
- Byte period B = SETUP_CYC + E_HIGH_CYC + WAIT_CYC clocks.
- Acceptance edge N: CMP during cycle N+1, SCAN N+2, first SETUP N+3; the first `lcd_e` rise is at edge N+3+SETUP_CYC.
- Refresh of k dirty lines: `refresh_done` is high in cycle N+2+k*(1+(CHARS+1)*B)+1, counting one SCAN per line plus the final SCAN. With k=0, `refresh_done` is in cycle N+3 and there is no bus activity.
- `frame_ready` returns high in the cycle after DONE, if `init_done`=1.

## Test plan
- Params LINES=2, CHARS=4, SETUP=1, E_HIGH=2, WAIT=3 (B=6); after reset, offer frame "ABCD","WXYZ" -> bus writes 0x80,'A','B','C','D',0xC0,'W','X','Y','Z'. Each E pulse is 2 cycles high; `refresh_done` fires at N+3+10*6+... as per the formula (= N+65).
- Same frame offered again -> no E pulses, `refresh_done` in cycle N+3, `busy` high for 3 cycles.
- Change only line 1 to "WXYQ" -> only 0xC0,'W','X','Y','Q' are written; line 0 is untouched.
- `frame_valid` held with `init_done`=0 -> `frame_ready`=0 and no acceptance; raise `init_done` -> accepted next edge.
- Assert `lcd_reset`=0 while E is high mid-line -> next edge `lcd_e`=0, `busy`=0. The next frame (identical to the previous one) rewrites all lines because shadow-valid was cleared.
- Drop `init_done` during a data byte -> that byte completes its WAIT, the block returns to IDLE with no `refresh_done`, and the next frame rewrites all lines.
